// File: rtl/rc4_encrypt_loop.sv
// RC4 keystream/encrypt engine: walks MSG_LENGTH plaintext bytes, swapping S-box entries
// in an external RAM and writing f XOR p to the ciphertext RAM. All RAM reads allow 2 wait states.
module rc4_encrypt_loop #(
  parameter int MSG_LENGTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_flag,
  output logic       done_flag,
  output logic       busy,
  output logic [7:0] addr,
  input  logic [7:0] rddata,
  output logic [7:0] wrdata,
  output logic       wren,
  output logic [7:0] addr_msg,
  input  logic [7:0] rddata_msg,
  output logic [7:0] addr_enc,
  output logic [7:0] wrdata_enc,
  output logic       wren_enc
);

  localparam logic [8:0] LP_LEN = 9'(MSG_LENGTH);

  typedef enum logic [4:0] {
    S_IDLE, S_CALC_I,
    S_RD_I, S_WAIT_I1, S_WAIT_I2, S_SAVE_I,
    S_RD_J, S_WAIT_J1, S_WAIT_J2, S_SAVE_J,
    S_WR_J, S_WR_I,
    S_RD_F, S_WAIT_F1, S_WAIT_F2, S_SAVE_F,
    S_RD_P, S_WAIT_P1, S_WAIT_P2, S_SAVE_P,
    S_XOR, S_WR_C, S_DONE
  } state_t;

  state_t     r_state;
  logic [7:0] r_i, r_j, r_si, r_sj, r_f, r_p, r_c;
  logic [8:0] r_k;
  logic [7:0] r_addr, r_wrdata, r_addr_msg, r_addr_enc;
  logic       r_wren, r_wren_enc, r_done, r_busy;

  function automatic logic [7:0] add8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  assign done_flag  = r_done;
  assign busy       = r_busy;
  assign addr       = r_addr;
  assign wrdata     = r_wrdata;
  assign wren       = r_wren;
  assign addr_msg   = r_addr_msg;
  assign addr_enc   = r_addr_enc;
  assign wrdata_enc = r_c;
  assign wren_enc   = r_wren_enc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_si       <= '0;
      r_sj       <= '0;
      r_f        <= '0;
      r_p        <= '0;
      r_c        <= '0;
      r_addr     <= '0;
      r_wrdata   <= '0;
      r_addr_msg <= '0;
      r_addr_enc <= '0;
      r_wren     <= 1'b0;
      r_wren_enc <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // DONE accepts a new run directly; S keeps whatever the last run left.
          if (start_flag) begin
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_CALC_I;
          end else if (r_state == S_DONE) begin
            r_done <= 1'b1;
          end
        end
        S_CALC_I: begin
          if (r_k < LP_LEN) begin
            r_i     <= add8(r_i, 8'd1);
            r_state <= S_RD_I;
          end else begin
            r_addr     <= '0;
            r_addr_msg <= '0;
            r_addr_enc <= '0;
            r_busy     <= 1'b0;
            r_state    <= S_DONE;
          end
        end
        S_RD_I: begin
          r_addr  <= r_i;
          r_state <= S_WAIT_I1;
        end
        S_WAIT_I1: r_state <= S_WAIT_I2;
        S_WAIT_I2: r_state <= S_SAVE_I;
        S_SAVE_I: begin
          r_si    <= rddata;
          r_j     <= add8(r_j, rddata);
          r_state <= S_RD_J;
        end
        S_RD_J: begin
          r_addr  <= r_j;
          r_state <= S_WAIT_J1;
        end
        S_WAIT_J1: r_state <= S_WAIT_J2;
        S_WAIT_J2: r_state <= S_SAVE_J;
        S_SAVE_J: begin
          // Write strobes are registered, so they are set up on entry to the write state.
          r_sj     <= rddata;
          r_addr   <= r_j;
          r_wrdata <= r_si;
          r_wren   <= 1'b1;
          r_state  <= S_WR_J;
        end
        S_WR_J: begin
          r_addr   <= r_i;
          r_wrdata <= r_sj;
          r_wren   <= 1'b1;
          r_state  <= S_WR_I;
        end
        S_WR_I: begin
          r_wren  <= 1'b0;
          r_state <= S_RD_F;
        end
        S_RD_F: begin
          r_addr  <= add8(r_si, r_sj);
          r_state <= S_WAIT_F1;
        end
        S_WAIT_F1: r_state <= S_WAIT_F2;
        S_WAIT_F2: r_state <= S_SAVE_F;
        S_SAVE_F: begin
          r_f     <= rddata;
          r_state <= S_RD_P;
        end
        S_RD_P: begin
          r_addr_msg <= r_k[7:0];
          r_state    <= S_WAIT_P1;
        end
        S_WAIT_P1: r_state <= S_WAIT_P2;
        S_WAIT_P2: r_state <= S_SAVE_P;
        S_SAVE_P: begin
          r_p     <= rddata_msg;
          r_state <= S_XOR;
        end
        S_XOR: begin
          r_c        <= r_f ^ r_p;
          r_addr_enc <= r_k[7:0];
          r_wren_enc <= 1'b1;
          r_state    <= S_WR_C;
        end
        S_WR_C: begin
          r_wren_enc <= 1'b0;
          r_k        <= r_k + 9'd1;
          r_state    <= S_CALC_I;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_encrypt_loop.sv
// Bench for rc4_encrypt_loop: RC4 reference model feeds a ciphertext scoreboard; a negedge
// monitor pops expectations on every ciphertext write and polices the S/ciphertext write slots.
module tb_rc4_encrypt_loop;
  localparam int N   = 9;
  localparam int LAT = 21 * N + 2;

  typedef struct packed { logic [7:0] a; logic [7:0] d; } enc_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start_flag, start1;
  logic       done_flag, busy, wren, wren_enc;
  logic [7:0] addr, rddata, wrdata, addr_msg, rddata_msg, addr_enc, wrdata_enc;
  logic       done1, busy1, wren1, wren_enc1;
  logic [7:0] addr1, rddata1, wrdata1, addr_msg1, rddata_msg1, addr_enc1, wrdata_enc1;

  int   total = 0, bad = 0;
  int   cyc = 0, acc_cyc = 0;
  bit   run_on = 1'b0;
  int   s_wr_total = 0, s_wr1_total = 0;
  enc_t exp_q[$];
  int   m_s[256];
  logic [7:0] s_init[256], msg_init[256];
  logic [7:0] s_mem[256], msg_mem[256], enc_mem[256], s_mem1[256], enc_mem1[256];
  logic [7:0] s_rd1, m_rd1, s1_rd1;
  logic       load0 = 1'b0, load1 = 1'b0;
  logic [7:0] kat[9];

  rc4_encrypt_loop #(.MSG_LENGTH(N)) u_dut (
    .clk(clk), .reset(reset), .start_flag(start_flag), .done_flag(done_flag), .busy(busy),
    .addr(addr), .rddata(rddata), .wrdata(wrdata), .wren(wren),
    .addr_msg(addr_msg), .rddata_msg(rddata_msg),
    .addr_enc(addr_enc), .wrdata_enc(wrdata_enc), .wren_enc(wren_enc));

  rc4_encrypt_loop #(.MSG_LENGTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .start_flag(start1), .done_flag(done1), .busy(busy1),
    .addr(addr1), .rddata(rddata1), .wrdata(wrdata1), .wren(wren1),
    .addr_msg(addr_msg1), .rddata_msg(rddata_msg1),
    .addr_enc(addr_enc1), .wrdata_enc(wrdata_enc1), .wren_enc(wren_enc1));

  // RAM models with two cycles of read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load0) begin
      for (int n = 0; n < 256; n++) begin
        s_mem[n]   <= s_init[n];
        msg_mem[n] <= msg_init[n];
        enc_mem[n] <= 8'h00;
      end
    end else begin
      if (wren) s_mem[addr] <= wrdata;
      if (wren_enc) enc_mem[addr_enc] <= wrdata_enc;
    end
    s_rd1 <= s_mem[addr];       rddata     <= s_rd1;
    m_rd1 <= msg_mem[addr_msg]; rddata_msg <= m_rd1;
    if (load1) begin
      for (int n = 0; n < 256; n++) begin
        s_mem1[n]   <= 8'(n);
        enc_mem1[n] <= 8'hFF;
      end
    end else begin
      if (wren1) s_mem1[addr1] <= wrdata1;
      if (wren_enc1) enc_mem1[addr_enc1] <= wrdata_enc1;
    end
    s1_rd1 <= s_mem1[addr1]; rddata1 <= s1_rd1;
  end
  assign rddata_msg1 = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    int   t;
    bit   ew, ee;
    enc_t e;
    t  = cyc - acc_cyc;
    ew = run_on && t < 21 * N && (t % 21 == 9 || t % 21 == 10);
    ee = run_on && t < 21 * N && t % 21 == 20;
    check("wren_slot", {31'd0, wren}, {31'd0, ew});
    check("wren_enc_slot", {31'd0, wren_enc}, {31'd0, ee});
    if (wren === 1'b1) s_wr_total++;
    if (wren1 === 1'b1) s_wr1_total++;
    if (wren_enc === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL enc_unexpected: write addr %0h data %0h, expected none", addr_enc, wrdata_enc);
      end else begin
        e = exp_q.pop_front();
        check("enc_addr", {24'd0, addr_enc}, {24'd0, e.a});
        check("enc_data", {24'd0, wrdata_enc}, {24'd0, e.d});
      end
    end
  end

  task automatic ksa(input string key);
    int j = 0, tmp;
    for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
    for (int n = 0; n < 256; n++) begin
      j = (j + int'(s_init[n]) + int'(key[n % key.len()])) % 256;
      tmp = s_init[n]; s_init[n] = s_init[j]; s_init[j] = 8'(tmp);
    end
  endtask

  task automatic load_mem();
    @(negedge clk); load0 = 1'b1;
    @(negedge clk); load0 = 1'b0;
    for (int n = 0; n < 256; n++) m_s[n] = int'(s_init[n]);
  endtask

  // Plain RC4 PRGA over the model S, continuing from its current contents.
  task automatic model_run();
    int i = 0, j = 0, tmp;
    enc_t e;
    for (int k = 0; k < N; k++) begin
      i = (i + 1) % 256;
      j = (j + m_s[i]) % 256;
      tmp = m_s[i]; m_s[i] = m_s[j]; m_s[j] = tmp;
      e.a = 8'(k);
      e.d = 8'(m_s[(m_s[i] + m_s[j]) % 256]) ^ msg_init[k];
      exp_q.push_back(e);
    end
  endtask

  task automatic accept();
    @(negedge clk); start_flag = 1'b1;
    @(posedge clk); #1; start_flag = 1'b0;
    acc_cyc = cyc;
    run_on  = 1'b1;
  endtask

  task automatic do_run(input string tag, input bit poke50);
    int lat = 0, base, diffs = 0;
    model_run();
    accept();
    base = s_wr_total;
    check({tag, "_done_low"}, {31'd0, done_flag}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    while (done_flag !== 1'b1 && lat < 2 * LAT) begin
      @(negedge clk); start_flag = poke50 && (cyc - acc_cyc == 50);
      @(posedge clk); #1; lat++;
    end
    start_flag = 1'b0;
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_s_writes"}, s_wr_total - base, 2 * N);
    check({tag, "_pending"}, exp_q.size(), 32'd0);
    for (int n = 0; n < 256; n++) if (s_mem[n] !== 8'(m_s[n])) diffs++;
    check({tag, "_s_state"}, diffs, 32'd0);
  endtask

  task automatic check_kat(input string tag);
    for (int n = 0; n < N; n++) check(tag, {24'd0, enc_mem[n]}, {24'd0, kat[n]});
  endtask

  initial begin
    string pt;
    int    guard, base, lat1, diffs, r, tmp;
    kat = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    pt  = "Plaintext";
    reset = 1'b1; start_flag = 1'b0; start1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", {31'd0, done_flag}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wren", {31'd0, wren}, 32'd0);
    check("rst_addr", {24'd0, addr}, 32'd0);
    check("rst_addr_enc", {24'd0, addr_enc}, 32'd0);
    reset = 1'b0;

    // Known-answer run, then a continuation run from the left-over S.
    ksa("Key");
    for (int n = 0; n < 256; n++) msg_init[n] = (n < N) ? pt[n] : 8'h00;
    load_mem();
    do_run("kat", 1'b0);
    check_kat("kat_byte");
    do_run("cont", 1'b0);

    // A start pulse mid-run must be ignored.
    ksa("Key");
    load_mem();
    do_run("poke", 1'b1);
    check_kat("poke_byte");

    // Reset during the ciphertext write of byte 3.
    ksa("Key");
    load_mem();
    model_run();
    accept();
    guard = 0;
    while ((cyc - acc_cyc) != 83 && guard < 200) begin @(negedge clk); guard++; end
    check("rst_mid_wren_enc_before", {31'd0, wren_enc}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    run_on = 1'b0;
    exp_q.delete();
    check("rst_mid_wren_enc", {31'd0, wren_enc}, 32'd0);
    check("rst_mid_wren", {31'd0, wren}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_addr", {24'd0, addr}, 32'd0);
    check("rst_mid_addr_msg", {24'd0, addr_msg}, 32'd0);
    check("rst_mid_addr_enc", {24'd0, addr_enc}, 32'd0);
    check("rst_mid_wrdata_enc", {24'd0, wrdata_enc}, 32'd0);
    reset = 1'b0;
    base = s_wr_total;
    repeat (30) @(posedge clk);
    #1;
    check("rst_mid_quiet", s_wr_total - base, 32'd0);
    ksa("Key");
    load_mem();
    do_run("after_rst", 1'b0);
    check_kat("after_rst_byte");

    // Random permutations and plaintexts.
    for (int it = 0; it < 3; it++) begin
      for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
      for (int n = 255; n > 0; n--) begin
        r = int'($urandom_range(n, 0));
        tmp = s_init[n]; s_init[n] = s_init[r]; s_init[r] = 8'(tmp);
      end
      for (int n = 0; n < 256; n++) msg_init[n] = 8'($urandom);
      load_mem();
      do_run("rand", 1'b0);
    end

    // Single-byte instance over an identity S-box.
    @(negedge clk); load1 = 1'b1;
    @(negedge clk); load1 = 1'b0;
    base = s_wr1_total;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    lat1 = 0;
    while (done1 !== 1'b1 && lat1 < 200) begin @(posedge clk); #1; lat1++; end
    check("one_latency", lat1, 32'd23);
    check("one_cipher", {24'd0, enc_mem1[0]}, 32'h02);
    check("one_s_writes", s_wr1_total - base, 32'd2);
    diffs = 0;
    for (int n = 0; n < 256; n++) if (s_mem1[n] !== 8'(n)) diffs++;
    check("one_s_unchanged", diffs, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rc4_encrypt_loop.md
RC4_ENCRYPT_LOOP -- requirements
Module: rc4_encrypt_loop

Interface
REQ-001 The block SHALL have parameter MSG_LENGTH, default 32, meaning number of message bytes processed per run (legal 1..256).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-003 The block SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-004 The block SHALL have port start_flag, input, 1, run request, sampled only in IDLE.
REQ-005 The block SHALL have port done_flag, output, 1, high from run completion until the next accepted start_flag.
REQ-006 The block SHALL have port busy, output, 1, high in every state except IDLE and DONE.
REQ-007 The block SHALL have ports addr, output, 8; rddata, input, 8; wrdata, output, 8; and wren, output, 1, forming the S-box RAM port.
REQ-008 The block SHALL have ports addr_msg, output, 8, and rddata_msg, input, 8, forming the plaintext RAM read port.
REQ-009 The block SHALL have ports addr_enc, output, 8; wrdata_enc, output, 8; and wren_enc, output, 1, forming the ciphertext RAM write port.

Function
REQ-010 All RAM reads SHALL hold the address stable and capture read data on the 3rd rising edge after the address register updates (2 wait states).
REQ-011 The block SHALL provide the states IDLE, CALC_I, RD_I, WAIT_I(x2), SAVE_I, RD_J, WAIT_J(x2), SAVE_J, WR_J, WR_I, RD_F, WAIT_F(x2), SAVE_F, RD_P, WAIT_P(x2), SAVE_P, XOR, WR_C, and DONE.
REQ-012 In IDLE with start_flag=1, the block SHALL clear i, j and k to 0 and done_flag to 0, then go to CALC_I; with start_flag=0 it SHALL remain in IDLE.
REQ-013 CALC_I: if k < MSG_LENGTH, the block SHALL set i=(i+1) mod 256 and go to RD_I; otherwise it SHALL go to DONE.
REQ-014 SAVE_I: the block SHALL latch si=rddata and set j=(j+rddata) mod 256 using 8-bit wrap.
REQ-015 SAVE_J: the block SHALL latch sj=rddata.
REQ-016 WR_J: the block SHALL drive addr=j, wrdata=si and wren=1 for exactly one cycle; WR_I: it SHALL drive addr=i, wrdata=sj and wren=1 for exactly one cycle, in that order.
REQ-017 When i==j, both writes SHALL target the same address with the same value, leaving S unchanged.
REQ-018 RD_F: the block SHALL drive addr=(si+sj) mod 256, and SAVE_F SHALL latch f=rddata.
REQ-019 RD_P: the block SHALL drive addr_msg=k, and SAVE_P SHALL latch p=rddata_msg.
REQ-020 XOR: the block SHALL compute c=f XOR p.
REQ-021 WR_C: the block SHALL drive addr_enc=k, wrdata_enc=c and wren_enc=1 for exactly one cycle, increment k, and go to CALC_I.
REQ-022 Each byte SHALL take exactly 21 cycles from CALC_I to CALC_I, and a run SHALL take MSG_LENGTH*21+2 cycles from start acceptance to done_flag high.
REQ-023 wren and wren_enc SHALL be 0 in every state other than the write states in REQ-016 and REQ-021.
REQ-024 k SHALL be 9 bits wide so that MSG_LENGTH=256 terminates correctly.
REQ-025 DONE: the block SHALL hold done_flag=1 and all addresses at 0; when start_flag=1 it SHALL return to IDLE semantics (REQ-012) on the same edge.
REQ-026 start_flag SHALL be ignored while busy=1.

Reset
REQ-027 When reset=1 at a clock edge, the block SHALL enter IDLE and clear i, j, k, si, sj, f, p, c, addr, addr_msg, addr_enc, wrdata, wrdata_enc, wren, wren_enc, done_flag and busy to 0, taking precedence over start_flag.
REQ-028 A reset mid-run SHALL abort the run with no further RAM writes; partially written S and ciphertext contents are not restored.

Verification
REQ-029 The bench SHALL preload S with the KSA result for key "Key", MSG_LENGTH=9 and plaintext "Plaintext", and pulse start_flag -> ciphertext RAM SHALL read BB F3 16 E8 D9 40 AF 0A D3, and done_flag SHALL rise 191 cycles after start acceptance.
REQ-030 The bench SHALL use S=identity (S[n]=n), MSG_LENGTH=1 and plaintext 0x00 -> i=1, j=1, the swap SHALL leave S unchanged, f=S[2]=0x02, and ciphertext[0] SHALL be 0x02.
REQ-031 The bench SHALL assert start_flag again at cycle 50 of a run -> there SHALL be no restart, i, j and k SHALL be unaffected, and the output SHALL match the REQ-029 result.
REQ-032 The bench SHALL assert reset during WR_C of byte 3 -> wren_enc SHALL be 0 on the next cycle, the block SHALL be in IDLE with all outputs 0, and a fresh run with a reloaded S SHALL produce the correct ciphertext.
REQ-033 The bench SHALL leave done_flag high and then assert start_flag -> done_flag SHALL fall on the next edge, and a second run SHALL continue from the current S state with i, j and k restarted at 0.
REQ-034 The bench SHALL check every cycle that wren and wren_enc are never high outside their write states, and that exactly 2*MSG_LENGTH S writes occur per run.
